// File: rtl/pmac_pkg.sv
// ---------------------------------------------------------------------------
// pmac_pkg
// Shared definitions for the packet MAC datapath: opcode encoding used by the
// packet controller (pctrl) and the execution unit (pmac_exec), plus the
// operand and result widths.
// ---------------------------------------------------------------------------
package pmac_pkg;

  localparam int DATA_W  = 32;
  localparam int RES_W   = 64;
  localparam int OP_W    = 3;
  // Number of cycles a result window actively shifts before idling high.
  localparam int RES_WIN = 64;
  // Window counter must be able to hold RES_WIN itself (saturation value).
  localparam int WCNT_W  = 7;
  // Multiplier iteration counter width (one iteration per multiplier bit).
  localparam int MCNT_W  = 5;

  typedef enum logic [OP_W-1:0] {
    OP_OUT_DATA1   = 3'd0,
    OP_OUT_DATA2   = 3'd1,
    OP_OUT_RES     = 3'd2,
    OP_OUT_RES_ADD = 3'd3,
    OP_LOAD_RES    = 3'd4,
    OP_MUL         = 3'd5,
    OP_MUL_ADD     = 3'd6,
    OP_NO_OP       = 3'd7
  } opcode_e;

  // Opcodes that touch res or the multiplier; these are refused while a
  // multiply is in flight.
  function automatic logic is_res_op(input opcode_e op);
    return (op == OP_MUL) || (op == OP_MUL_ADD) || (op == OP_LOAD_RES) ||
           (op == OP_OUT_RES) || (op == OP_OUT_RES_ADD);
  endfunction

  // Full-adder carry out.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pmul_seq.sv
// ---------------------------------------------------------------------------
// pmul_seq
// Iterative 32x32 -> 64-bit two's complement multiplier, one multiplier bit
// per clock (shift-and-add, with the MSB partial product subtracted so the
// signed weight of b[31] is honoured).
//
// Ports
//   clk    in   clock, rising edge
//   nRst   in   asynchronous active-low reset, aborts any multiply
//   start  in   latch a/b and begin; ignored while busy
//   a, b   in   signed operands
//   busy   out  high for the 32 iteration cycles following start
//   done   out  1-cycle pulse during the last iteration cycle; p is valid
//               in that same cycle (it is the final accumulator value)
//   p      out  signed 64-bit product, qualified by done
// ---------------------------------------------------------------------------
module pmul_seq
  import pmac_pkg::*;
(
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic signed [RES_W-1:0]  p
);

  logic                    r_busy;
  logic [MCNT_W-1:0]       r_cnt;
  logic signed [RES_W-1:0] r_acc;
  logic signed [RES_W-1:0] r_mcand;
  logic [DATA_W-1:0]       r_mplier;

  logic                    w_last;
  logic signed [RES_W-1:0] w_addend;
  logic signed [RES_W-1:0] w_acc_nxt;

  assign w_last = (r_cnt == MCNT_W'(DATA_W - 1));

  // b[31] carries weight -2^31, so its partial product is subtracted.
  always_comb begin
    w_addend = '0;
    if (r_mplier[0]) begin
      w_addend = w_last ? -r_mcand : r_mcand;
    end
  end

  assign w_acc_nxt = r_acc + w_addend;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand <<< 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + MCNT_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= RES_W'(a);
      r_mplier <= b;
    end
  end

  assign busy = r_busy;
  // The final sum is forwarded combinationally so the caller can commit the
  // product on the same edge that busy falls.
  assign done = r_busy & w_last;
  assign p    = w_acc_nxt;

endmodule

// File: rtl/pmac_exec.sv
// ---------------------------------------------------------------------------
// pmac_exec
// Serial execution unit of the packet MAC. Holds two 32-bit operands, a
// 64-bit result register and a serial-add carry. Operands and result move in
// and out LSB first over rx/tx under control of a held opcode; multiply and
// multiply-accumulate are launched by single-cycle opcode pulses and run on
// the iterative multiplier pmul_seq.
//
// Ports
//   clk     in   clock, rising edge
//   nRst    in   asynchronous active-low reset
//   opcode  in   command (pmac_pkg::opcode_e encoding), NO_OP when idle
//   rx      in   serial data in, one bit per clock
//   tx      out  registered serial data out, idles high
//   busy    out  multiply in progress
//   err     out  sticky: a res/multiplier opcode arrived while busy
// ---------------------------------------------------------------------------
module pmac_exec
  import pmac_pkg::*;
(
  input  logic            clk,
  input  logic            nRst,
  input  logic [OP_W-1:0] opcode,
  input  logic            rx,
  output logic            tx,
  output logic            busy,
  output logic            err
);

  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic [RES_W-1:0]  r_res;
  logic              r_carry;
  logic [WCNT_W-1:0] r_cnt;
  opcode_e           r_prev_op;   // opcode accepted on the previous cycle
  logic              r_tx;
  logic              r_err;
  logic              r_mul_add;   // launched multiply accumulates into res

  opcode_e           w_op;
  opcode_e           w_acc_op;
  logic              w_reject;
  logic              w_entry;
  logic [WCNT_W-1:0] w_cnt;
  logic              w_carry;
  logic              w_in_win;
  logic              w_load_end;
  logic [RES_W-1:0]  w_res_base;
  logic [RES_W-1:0]  w_res_rot;
  logic              w_sum;
  logic              w_cout;
  logic              w_start;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic signed [RES_W-1:0] w_prod;

  assign w_op     = opcode_e'(opcode);
  assign w_reject = w_mul_busy & is_res_op(w_op);
  // A refused opcode behaves exactly like NO_OP, including for window
  // tracking, so a window that outlives busy starts cleanly when accepted.
  assign w_acc_op = w_reject ? OP_NO_OP : w_op;

  // Windows are delimited purely by opcode changes; no cycle count is
  // assumed for the controller.
  assign w_entry    = (w_acc_op != r_prev_op);
  assign w_cnt      = w_entry ? '0 : r_cnt;
  assign w_carry    = w_entry ? 1'b0 : r_carry;
  assign w_in_win   = (w_cnt < WCNT_W'(RES_WIN));

  // Sign extension after LOAD_RES is folded into the base value so an opcode
  // that follows LOAD_RES directly already sees the extended result.
  assign w_load_end = (r_prev_op == OP_LOAD_RES) && (w_acc_op != OP_LOAD_RES);
  assign w_res_base = w_load_end ? {{(RES_W-DATA_W){r_res[DATA_W-1]}}, r_res[DATA_W-1:0]}
                                 : r_res;
  assign w_res_rot  = {w_res_base[0], w_res_base[RES_W-1:1]};

  assign w_sum  = rx ^ w_res_base[0] ^ w_carry;
  assign w_cout = majority3(rx, w_res_base[0], w_carry);

  assign w_start = (w_acc_op == OP_MUL) || (w_acc_op == OP_MUL_ADD);

  pmul_seq u_mul (
    .clk   (clk),
    .nRst  (nRst),
    .start (w_start),
    .a     (r_data1),
    .b     (r_data2),
    .busy  (w_mul_busy),
    .done  (w_mul_done),
    .p     (w_prod)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_data1   <= '0;
      r_data2   <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_prev_op <= OP_NO_OP;
      r_tx      <= 1'b1;
      r_err     <= 1'b0;
      r_mul_add <= 1'b0;
    end else begin
      r_tx      <= 1'b1;
      r_prev_op <= w_acc_op;
      r_res     <= w_res_base;
      if (w_reject) begin
        r_err <= 1'b1;
      end

      case (w_acc_op)
        OP_OUT_DATA1: begin
          r_data1 <= {rx, r_data1[DATA_W-1:1]};
          r_tx    <= r_data1[0];
        end
        OP_OUT_DATA2: begin
          r_data2 <= {rx, r_data2[DATA_W-1:1]};
          r_tx    <= r_data2[0];
        end
        OP_LOAD_RES: begin
          r_res <= {r_res[RES_W-1:DATA_W], rx, r_res[DATA_W-1:1]};
        end
        OP_OUT_RES: begin
          r_carry <= 1'b0;
          r_cnt   <= w_cnt;
          if (w_in_win) begin
            r_tx  <= w_res_base[0];
            r_res <= w_res_rot;
            r_cnt <= w_cnt + WCNT_W'(1);
          end
        end
        OP_OUT_RES_ADD: begin
          r_carry <= w_carry;
          r_cnt   <= w_cnt;
          if (w_in_win) begin
            // Sum only goes to tx; res just rotates back to itself.
            r_tx    <= w_sum;
            r_carry <= w_cout;
            r_res   <= w_res_rot;
            r_cnt   <= w_cnt + WCNT_W'(1);
          end
        end
        OP_MUL, OP_MUL_ADD: begin
          r_mul_add <= (w_acc_op == OP_MUL_ADD);
        end
        default: ;
      endcase

      // While busy no accepted opcode touches res, so the commit cannot
      // collide with a window.
      if (w_mul_done) begin
        r_res <= r_mul_add ? (r_res + RES_W'(w_prod)) : RES_W'(w_prod);
      end
    end
  end

  assign tx   = r_tx;
  assign busy = w_mul_busy;
  assign err  = r_err;

endmodule

// File: doc/pmac_exec.md
PMAC_EXEC -- requirements
Module: pmac_exec

Interface
REQ-001 clk  input  1  system clock, all state on rising edge.
REQ-002 nRst  input  1  reset, asynchronous, active-low.
REQ-003 opcode  input  3  command from the packet controller; NO_OP (7) when idle; MUL/MUL_ADD arrive as 1-cycle pulses; other opcodes are held for a whole window.
REQ-004 rx  input  1  serial data, LSB first, one bit per clk while a shift opcode is held.
REQ-005 tx  output  1  registered serial output, LSB first; idles high.
REQ-006 busy  output  1  high while the iterative multiply is in progress.
REQ-007 err  output  1  sticky flag, set when a rejected opcode arrives during busy.

Function
REQ-010 Registers: data1[31:0], data2[31:0], res[63:0], carry; all values are two's complement.
REQ-011 Opcode encoding: OUT_DATA1=0, OUT_DATA2=1, OUT_RES=2, OUT_RES_ADD=3, LOAD_RES=4, MUL=5, MUL_ADD=6, NO_OP=7.
REQ-012 OUT_DATA1, per cycle held: data1 <= {rx, data1[31:1]} and tx <= data1[0]. This is shift-through, so a 32-cycle window emits the old value and loads the new one.
REQ-013 OUT_DATA2 behaves as REQ-012 on data2.
REQ-014 LOAD_RES, per cycle held: shift rx into res[31:0] LSB first.
REQ-014a At the end of the LOAD_RES window, res[63:32] takes the sign of res[31]; tx stays 1.
REQ-014b Window end for any held opcode is detected as opcode changing away from it; cycle counts are not assumed.
REQ-015 OUT_RES: for the first 64 cycles held, tx <= res[0] and res rotates right by 1; for later cycles tx <= 1. After a 64-cycle window res is unchanged.
REQ-016 OUT_RES_ADD: bit-serial adder. For the first 64 cycles, tx <= rx ^ res[0] ^ carry and carry <= majority(rx, res[0], carry); res rotates right by 1.
REQ-016a After the first 64 OUT_RES_ADD cycles, tx <= 1. The final carry is discarded, so the sum wraps modulo 2^64.
REQ-017 Carry and the 64-bit window counter clear on every entry into OUT_RES or OUT_RES_ADD.
REQ-018 MUL pulse: latch data1 and data2 into the multiplier, raise busy next cycle, and run 32 iterations. On completion, res <= product (64-bit signed) and busy falls.
REQ-018a Latency from the MUL pulse cycle to busy low with res valid is exactly 33 cycles.
REQ-019 MUL_ADD: as MUL, but res <= res + product, wrapping modulo 2^64.
REQ-020 While busy, OUT_DATA1/OUT_DATA2 are accepted, because operands are already latched.
REQ-020a While busy, MUL, MUL_ADD, LOAD_RES, OUT_RES and OUT_RES_ADD are ignored (tx stays 1) and set err; NO_OP is always legal.
REQ-021 err clears only on reset.
REQ-022 NO_OP or an unrecognised opcode: tx <= 1 and no register changes.
REQ-023 MUL with data1 = 0x80000000 and data2 = 0x80000000 gives 0x4000000000000000; no overflow is possible for MUL.

Reset
REQ-030 Asynchronous nRst low forces: tx=1, busy=0, err=0, data1=0, data2=0, res=0, carry=0, window counter=0, multiplier idle.
REQ-031 Reset during a multiply aborts it; no partial result is written to res.
REQ-032 After release, the first opcode is acted on in the first clk edge.

Structure
REQ-040 Opcode constants, DATA_W=32 and RES_W=64 live in the shared package pmac_pkg, which pctrl also imports.
REQ-041 The iterative signed multiplier is a sub-module pmul_seq.
REQ-041a pmul_seq ports: clk, nRst, start, a[31:0], b[31:0], busy, done (1-cycle pulse), p[63:0]. It holds one iteration counter and takes 32 cycles.
REQ-042 The top level holds the shift, serial-add and window control; target size is 200-300 lines total.

Verification
REQ-050 Load data1=3 and data2=-5 (32-cycle windows each), then pulse MUL -> busy high for 32 cycles, low at cycle 33. A 128-cycle OUT_RES window then emits 0xFFFFFFFFFFFFFFF1 LSB first followed by 64 ones.
REQ-051 data1 = data2 = 0x7FFFFFFF, res=0, two MUL_ADD pulses (spaced 40 cycles) -> res=0x7FFFFFFE00000002.
REQ-052 LOAD_RES 0x80000000 -> res=0xFFFFFFFF80000000. Then OUT_RES_ADD with rx streaming 64-bit value 1 -> tx emits 0xFFFFFFFF80000001.
REQ-053 res=0xFFFFFFFFFFFFFFFF with OUT_RES_ADD and rx=1 -> tx emits 64 zeros. A following OUT_RES_ADD with rx=0 emits res unchanged, proving carry was cleared.
REQ-054 Pulse MUL, then assert OUT_RES 10 cycles later -> tx stays 1 and err=1. res still becomes the correct product at cycle 33.
REQ-055 Preload data1=0xA5 and run an OUT_DATA1 window with rx=0x12345678 -> tx emits 0x000000A5 and data1=0x12345678. Reset mid-multiply -> busy=0, res=0, tx=1.
